// File: rtl/traffic_light_pkg.sv
// rtl/traffic_light_pkg.sv - light encodings, phase order, error bits and FSM states
package traffic_light_pkg;

  typedef logic [1:0] light_t;

  localparam light_t GREEN   = 2'b00;
  localparam light_t YELLOW  = 2'b01;
  localparam light_t RED     = 2'b10;
  localparam light_t ILLEGAL = 2'b11;

  localparam int ERR_ILLEGAL = 0;
  localparam int ERR_SEQ     = 1;
  localparam int ERR_DEC     = 2;
  localparam int ERR_RELOAD  = 3;

  localparam logic [0:0] UNLOCKED = 1'b0;
  localparam logic [0:0] LOCKED   = 1'b1;

  // ILLEGAL maps to itself so an illegal previous code can never be followed legally
  function automatic light_t next_phase(input light_t l);
    case (l)
      GREEN:   next_phase = YELLOW;
      YELLOW:  next_phase = RED;
      RED:     next_phase = GREEN;
      default: next_phase = ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_monitor_sat_counter.sv
// rtl/traffic_light_monitor_sat_counter.sv - up counter that sticks at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive checker for the traffic-light status interface
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int TW    = 8,
  parameter int CYC_W = 16,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       light,
  input  logic [TW-1:0]    timee,
  input  logic [TW-1:0]    green_time,
  input  logic [TW-1:0]    yellow_time,
  input  logic [TW-1:0]    red_time,
  input  logic             clr_err,
  output logic             locked,
  output logic [1:0]       cur_phase,
  output logic             phase_done,
  output logic [CYC_W-1:0] full_cycles,
  output logic [3:0]       err_flags,
  output logic [ERR_W-1:0] err_cnt
);

  logic [0:0]    state;
  light_t        prev_light;
  logic [TW-1:0] prev_time;
  logic [TW-1:0] cfg_time;
  light_t        want_light;
  logic          same_light, next_light, dec_ok, reload_ok, is_illegal, at_boundary;
  logic [3:0]    errs;
  logic          accept, any_err;

  // Match bits are resolved through if/else so unknown inputs fall to "no match"
  always_comb begin
    want_light  = next_phase(prev_light);
    cfg_time    = '0;
    same_light  = 1'b0;
    next_light  = 1'b0;
    dec_ok      = 1'b0;
    reload_ok   = 1'b0;
    is_illegal  = 1'b0;
    at_boundary = 1'b0;
    case (light)
      GREEN:   cfg_time = green_time;
      YELLOW:  cfg_time = yellow_time;
      RED:     cfg_time = red_time;
      default: cfg_time = '0;
    endcase
    if (light == ILLEGAL)                          is_illegal  = 1'b1;
    if (light == prev_light)                       same_light  = 1'b1;
    if (light == want_light && light != ILLEGAL)   next_light  = 1'b1;
    if (timee == prev_time - TW'(1))               dec_ok      = 1'b1;
    if (timee == cfg_time)                         reload_ok   = 1'b1;
    if (prev_time == '0)                           at_boundary = 1'b1;
  end

  always_comb begin
    errs   = '0;
    accept = 1'b0;
    if (en) begin
      errs[ERR_ILLEGAL] = is_illegal;
      if (at_boundary) begin
        accept = next_light && reload_ok;
        if (state == LOCKED) begin
          errs[ERR_SEQ]    = !next_light;
          errs[ERR_RELOAD] = next_light && !reload_ok;
        end
      end else if (state == LOCKED) begin
        errs[ERR_SEQ] = !same_light;
        errs[ERR_DEC] = !dec_ok;
      end
    end
  end

  assign any_err = |errs;
  assign locked  = (state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_light  <= GREEN;
      prev_time   <= '0;
      state       <= UNLOCKED;
      cur_phase   <= GREEN;
      phase_done  <= 1'b0;
      full_cycles <= '0;
      err_flags   <= '0;
    end else begin
      prev_light <= light;
      prev_time  <= timee;
      phase_done <= accept && !any_err;
      err_flags  <= (clr_err ? 4'b0000 : err_flags) | errs;
      if (!en || any_err) begin
        state <= UNLOCKED;
      end else if (accept) begin
        state     <= LOCKED;
        cur_phase <= light;
        if (prev_light == RED && light == GREEN) begin
          full_cycles <= full_cycles + CYC_W'(1);
        end
      end
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (any_err),
    .count (err_cnt)
  );

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - scoreboard bench for traffic_light_monitor
module tb_traffic_light_monitor;

  localparam logic [1:0] G = 2'b00, Y = 2'b01, R = 2'b10, X = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic [1:0]  light = G;
  logic [7:0]  timee = '0;
  logic [7:0]  green_time = 8'd3, yellow_time = 8'd1, red_time = 8'd5;
  logic        clr_err = 1'b0;
  logic        locked, phase_done;
  logic [1:0]  cur_phase;
  logic [15:0] full_cycles;
  logic [3:0]  err_flags;
  logic [7:0]  err_cnt;

  int checks = 0;
  int failures = 0;

  traffic_light_monitor dut (
    .clk(clk), .rst_n(rst_n), .en(en), .light(light), .timee(timee),
    .green_time(green_time), .yellow_time(yellow_time), .red_time(red_time),
    .clr_err(clr_err), .locked(locked), .cur_phase(cur_phase),
    .phase_done(phase_done), .full_cycles(full_cycles),
    .err_flags(err_flags), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lk;
    logic [1:0]  cp;
    logic        pd;
    logic [15:0] fc;
    logic [3:0]  fl;
    logic [7:0]  ec;
  } exp_t;

  exp_t sbq[$];

  logic        m_lk;
  logic [1:0]  m_pl, m_cp;
  logic [7:0]  m_pt, m_ec;
  logic [15:0] m_fc;
  logic [3:0]  m_fl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] b_next(input logic [1:0] l);
    return (l == G) ? Y : (l == Y) ? R : (l == R) ? G : X;
  endfunction

  function automatic logic [7:0] b_cfg(input logic [1:0] l);
    return (l == G) ? green_time : (l == Y) ? yellow_time : (l == R) ? red_time : 8'd0;
  endfunction

  task automatic model_reset();
    m_lk = 0; m_pl = G; m_pt = 0; m_cp = G; m_ec = 0; m_fc = 0; m_fl = 0;
  endtask

  // Model: predict what a legal controller would show next, then classify the deviation
  task automatic step(input logic [1:0] l, input logic [7:0] t, input logic e = 1'b1, input logic c = 1'b0);
    exp_t x;
    logic [3:0] errs;
    logic [1:0] wl;
    logic [7:0] wt;
    logic bnd, ok;
    @(negedge clk);
    light = l; timee = t; en = e; clr_err = c;
    errs = 0; x.pd = 0;
    bnd = (m_pt == 0);
    wl  = bnd ? b_next(m_pl) : m_pl;
    wt  = bnd ? b_cfg(wl) : m_pt - 8'd1;
    ok  = bnd && (l == wl) && (l != X) && (t == wt);
    if (e) begin
      if (l == X) errs[0] = 1;
      if (m_lk && l != wl) errs[1] = 1;
      if (m_lk && !bnd && t != wt) errs[2] = 1;
      if (m_lk && bnd && l == wl && t != wt) errs[3] = 1;
      if (errs != 0) begin
        m_lk = 0;
        if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
      end else if (ok) begin
        m_lk = 1; x.pd = 1; m_cp = l;
        if (m_pl == R && l == G) m_fc = m_fc + 16'd1;
      end
    end else begin
      m_lk = 0;
    end
    m_fl = (c ? 4'b0 : m_fl) | errs;
    m_pl = l; m_pt = t;
    x.lk = m_lk; x.cp = m_cp; x.fc = m_fc; x.fl = m_fl; x.ec = m_ec;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      x = sbq.pop_front();
      check("locked", locked, x.lk);
      check("cur_phase", cur_phase, x.cp);
      check("phase_done", phase_done, x.pd);
      check("full_cycles", full_cycles, x.fc);
      check("err_flags", err_flags, x.fl);
      check("err_cnt", err_cnt, x.ec);
    end
  endtask

  task automatic run(input logic [1:0] l, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) step(l, 8'(i));
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_locked", locked, 0);
    check("rst_flags", err_flags, 0);
    check("rst_cnt", err_cnt, 0);
    check("rst_full", full_cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run(G, 3, 0); run(Y, 1, 0); run(R, 5, 0); step(G, 3);
    check("seq_locked", locked, 1);
    check("seq_full", full_cycles, 1);
    check("seq_flags", err_flags, 0);

    step(G, 1);
    check("dec_flags", err_flags, 4'b0100);
    check("dec_cnt", err_cnt, 1);
    check("dec_unlock", locked, 0);
    step(G, 0); step(Y, 1);
    check("relock", locked, 1);
    check("relock_flag_sticky", err_flags, 4'b0100);

    step(Y, 0); run(R, 5, 0); run(G, 3, 0); step(R, 5);
    check("seq_err", err_flags[1], 1);
    check("seq_full_hold", full_cycles, 2);

    run(R, 4, 0); step(G, 3); run(G, 2, 1); step(G, 0, 1, 1); step(Y, 2);
    check("reload_flags", err_flags, 4'b1000);
    check("reload_cnt", err_cnt, 3);

    step(Y, 1, 1, 1); step(X, 0);
    check("illegal_flags", err_flags, 4'b0001);
    step(X, 0, 0, 0);
    check("illegal_en0_cnt", err_cnt, 4);

    step(R, 5); run(R, 4, 0); step(G, 3); run(G, 2, 1); step(G, 0, 1, 1);
    step(Y, 1); step(Y, 0); step(R, 5); step(R, 3, 1, 1);
    check("clr_vs_set", err_flags, 4'b0100);

    step(R, 2); step(R, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_locked", locked, 0);
    check("async_full", full_cycles, 0);
    check("async_flags", err_flags, 0);
    check("async_cnt", err_cnt, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    run(G, 3, 0); run(Y, 1, 1); step(Y, 0, 0, 0); step(R, 5);
    for (int i = 0; i < 300; i++) step(X, 0);
    check("sat_cnt", err_cnt, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
Passive receiver for the traffic-light controller's status interface (light code plus countdown value). It checks every cycle that the sequence and countdown are legal against the configured phase durations. It reports phase boundaries, counts completed green-yellow-red cycles, and raises sticky error flags. It sits beside the controller in the system and in benches, as a protocol checker and status source.

Parameters:
TW, 8, width of countdown and configured phase times
CYC_W, 16, width of completed-cycle counter
ERR_W, 8, width of saturating error counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  monitoring enable
light  in  2  observed light code: 00 green, 01 yellow, 10 red, 11 illegal
timee  in  TW  observed remaining time of current phase
green_time  in  TW  configured green duration
yellow_time  in  TW  configured yellow duration
red_time  in  TW  configured red duration
clr_err  in  1  clears err_flags (not err_cnt)
locked  out  1  monitor synchronised to the controller sequence
cur_phase  out  2  last accepted light code
phase_done  out  1  one-cycle pulse on each accepted phase change
full_cycles  out  CYC_W  count of accepted red-to-green transitions, wraps
err_flags  out  4  sticky: [0] illegal code, [1] bad sequence, [2] bad decrement, [3] bad reload
err_cnt  out  ERR_W  errored cycles, saturates at all-ones

Behaviour:
- Reset (async assert, sync release): all outputs 0, cur_phase=00, FSM UNLOCKED, prev_light=00, prev_time=0.
- prev_light and prev_time register light and timee every cycle, regardless of en.
- Checks compare the current inputs against the prev_* values. Results are registered, so outputs update after the edge that samples the offending or transitioning value (latency 1).
- Interface contract: within a phase, timee decrements by exactly 1 per cycle. When prev_time==0, the next cycle must show next(prev_light) with timee equal to that phase's configured time. Phase length is cfg+1 cycles.
- next(): green->yellow->red->green.
- FSM, UNLOCKED:
  - Only check [0] is active.
  - Go to LOCKED when prev_time==0, light==next(prev_light) and timee==cfg(light). This transition counts as an accepted phase change.
- FSM, LOCKED, checks each cycle:
  - light==11 -> [0].
  - prev_time!=0 and light!=prev_light -> [1].
  - prev_time!=0 and timee!=prev_time-1 -> [2]. No wrap is possible because prev_time!=0.
  - prev_time==0 and light!=next(prev_light) -> [1]. This includes the light being held.
  - prev_time==0, light correct, timee!=cfg(light) -> [3].
  - Any error -> UNLOCKED the next cycle. err_cnt+1 once per errored cycle, saturating.
- Accepted phase change:
  - phase_done=1 for one cycle and cur_phase<=light.
  - If the change is red->green, full_cycles+1 (wraps at 2^CYC_W).
- Config inputs are sampled only at the reload check. Changes mid-phase take effect at the next boundary.
- clr_err: clears err_flags next cycle. If a new error occurs in the same cycle, set wins for that bit.
- en=0: FSM forced UNLOCKED, no checks, no error set, phase_done=0. Counters and flags hold.
- Illegal code while UNLOCKED: sets [0] and counts in err_cnt.
- X/Z on inputs (controller uninitialised): must not produce a lock. Checks treat a non-0/1 compare as no match.

Decomposition:
- Package traffic_light_pkg holds:
  - light encodings GREEN/YELLOW/RED/ILLEGAL
  - next_phase function
  - error bit index constants
  - FSM state encoding (UNLOCKED, LOCKED)
- One natural sub-module, sat_counter (parameterised width, inc, saturate), used for err_cnt.
- The cycle counter is a plain wrapping register, kept inline.

Test Plan:
- Config 3/1/5: drive green 3,2,1,0, yellow 1,0, red 5..0, green 3 -> locked=1 after green->yellow. phase_done pulses at yellow, red and green entry. full_cycles=1, err_flags=0, err_cnt=0.
- Locked in green, drive timee 3 then 1 -> err_flags=0100, err_cnt=1, locked=0. Relock at the next legal boundary, flag stays set.
- Locked, green timee 0 then red 5 -> err_flags[1]=1, locked=0, full_cycles unchanged.
- Locked, green 0 then yellow 2 (cfg 1) -> err_flags[3]=1, err_cnt=1.
- light=11 while UNLOCKED and en=1 -> err_flags[0]=1, err_cnt=1. Same with en=0 -> no change.
- Pulse rst_n low mid-red -> all outputs 0 immediately, without waiting for a clock edge. Separately, clr_err with a same-cycle decrement error -> err_flags=0100 retained. err_cnt saturates at 255 after 300 forced errors.
